// File: rtl/data_memory_unit_pkg.sv
// rtl/data_memory_unit_pkg.sv - shared funct3 codes, FSM states and lane helpers for the load/store unit
package data_memory_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int BLOCK_MEMORY_SIZE = 12;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    LOAD_DATA   = 2'd1,
    STORE_READ  = 2'd2,
    STORE_WRITE = 2'd3
  } dmu_state_t;

  // Lane select plus sign/zero extension; shared by the RAM and MMIO load paths.
  function automatic logic [31:0] load_align(input logic [31:0] word, input logic [1:0] offset,
                                             input logic [2:0] funct3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (offset)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   r = {{24{b[7]}}, b};
      F3_LH:   r = {{16{h[15]}}, h};
      F3_LBU:  r = {24'h0, b};
      F3_LHU:  r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] offset,
                                              input logic [2:0] funct3, input logic [31:0] data);
    logic [31:0] m;
    m = word;
    case (funct3)
      F3_SB: begin
        case (offset)
          2'd0:    m[7:0]   = data[7:0];
          2'd1:    m[15:8]  = data[7:0];
          2'd2:    m[23:16] = data[7:0];
          default: m[31:24] = data[7:0];
        endcase
      end
      F3_SH: begin
        if (offset[1]) m[31:16] = data[15:0];
        else           m[15:0]  = data[15:0];
      end
      default: m = data;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/block_memory.sv
// rtl/block_memory.sv - single-port word RAM, one-cycle synchronous read and synchronous write
module block_memory #(
  parameter int ADDRESS_SIZE = 12
) (
  input  logic                    clk,
  input  logic [ADDRESS_SIZE-1:0] address,
  input  logic                    write_enable,
  input  logic [31:0]             write_data,
  output logic [31:0]             read_data
);

  logic [31:0] mem [0:(1<<ADDRESS_SIZE)-1];

  always_ff @(posedge clk) begin
    if (write_enable) mem[address] <= write_data;
    read_data <= mem[address];
  end

endmodule

// File: rtl/data_memory_unit.sv
// rtl/data_memory_unit.sv - RV32I load/store unit: block_memory RMW FSM, byte-wide MMIO channels, error flags
module data_memory_unit
  import data_memory_unit_pkg::*;
#(
  parameter int          ADDRESS_SIZE  = BLOCK_MEMORY_SIZE,
  parameter logic [31:0] MMIO_BASE     = 32'h2000,
  parameter int          MMIO_CHANNELS = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [2:0]                 subfunction_3,
  input  logic [31:0]                input_register1_value,
  input  logic [31:0]                input_register2_value,
  input  logic [31:0]                immediate,
  input  logic                       opcode_is_load,
  input  logic                       opcode_is_store,
  input  logic [8*MMIO_CHANNELS-1:0] memory_mapped_input,
  output logic                       clk_stall,
  output logic                       decoding_error,
  output logic                       misaligned_error,
  output logic [31:0]                result_to_write_rd,
  output logic [8*MMIO_CHANNELS-1:0] memory_mapped_io,
  output logic [MMIO_CHANNELS-1:0]   mmio_write_strobe
);

  dmu_state_t              state;
  logic [31:0]             ea;
  logic                    load_f3_ok, store_f3_ok, decode_bad, misalign;
  logic                    req_ok, ram_req, mmio_hit, mmio_load_now;
  logic [MMIO_CHANNELS-1:0] mmio_sel;
  logic [7:0]              mmio_byte;
  logic [ADDRESS_SIZE-1:0] mem_addr, addr_q;
  logic [1:0]              off_q;
  logic [2:0]              f3_q;
  logic [31:0]             rs2_q, merge_q, result_q, mem_rdata, load_value, mmio_value;

  assign ea = input_register1_value + immediate;

  assign load_f3_ok  = subfunction_3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  assign store_f3_ok = subfunction_3 inside {F3_SB, F3_SH, F3_SW};
  assign decode_bad  = (opcode_is_load && opcode_is_store) ||
                       (opcode_is_load && !load_f3_ok) || (opcode_is_store && !store_f3_ok);
  assign misalign    = ((subfunction_3[1:0] == 2'b01) && ea[0]) ||
                       ((subfunction_3[1:0] == 2'b10) && (ea[1:0] != 2'b00));

  always_comb begin
    mmio_sel  = '0;
    mmio_byte = 8'h00;
    for (int k = 0; k < MMIO_CHANNELS; k++) begin
      if (ea[31:2] == MMIO_BASE[31:2] + 30'(k)) begin
        mmio_sel[k] = 1'b1;
        mmio_byte   = memory_mapped_input[8*k +: 8];
      end
    end
  end

  // reset_n gates acceptance so an asserted reset also drops the combinational stall.
  assign mmio_hit      = |mmio_sel;
  assign req_ok        = reset_n && (state == IDLE) && (opcode_is_load || opcode_is_store) &&
                         !decode_bad && !misalign;
  assign ram_req       = req_ok && !mmio_hit;
  assign mmio_load_now = req_ok && mmio_hit && opcode_is_load;
  assign clk_stall     = ((state == IDLE) && ram_req) || (state == STORE_READ);

  assign mem_addr   = (state == IDLE) ? ea[ADDRESS_SIZE+1:2] : addr_q;
  assign load_value = load_align(mem_rdata, off_q, f3_q);
  assign mmio_value = load_align({24'h0, mmio_byte}, 2'b00, subfunction_3);

  assign result_to_write_rd = (state == LOAD_DATA) ? load_value :
                              mmio_load_now        ? mmio_value : result_q;

  block_memory #(.ADDRESS_SIZE(ADDRESS_SIZE)) u_block_memory (
    .clk          (clk),
    .address      (mem_addr),
    .write_enable (state == STORE_WRITE),
    .write_data   (merge_q),
    .read_data    (mem_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      addr_q            <= '0;
      off_q             <= '0;
      f3_q              <= '0;
      rs2_q             <= '0;
      merge_q           <= '0;
      result_q          <= '0;
      memory_mapped_io  <= '0;
      mmio_write_strobe <= '0;
      decoding_error    <= 1'b0;
      misaligned_error  <= 1'b0;
    end else begin
      mmio_write_strobe <= '0;
      case (state)
        IDLE: begin
          addr_q <= ea[ADDRESS_SIZE+1:2];
          off_q  <= ea[1:0];
          f3_q   <= subfunction_3;
          rs2_q  <= input_register2_value;
          if (decode_bad) decoding_error <= 1'b1;
          else if ((opcode_is_load || opcode_is_store) && misalign) misaligned_error <= 1'b1;
          if (req_ok && mmio_hit) begin
            if (opcode_is_store) begin
              for (int k = 0; k < MMIO_CHANNELS; k++)
                if (mmio_sel[k]) memory_mapped_io[8*k +: 8] <= input_register2_value[7:0];
              mmio_write_strobe <= mmio_sel;
            end else begin
              result_q <= mmio_value;
            end
          end else if (ram_req) begin
            state <= opcode_is_load ? LOAD_DATA : STORE_READ;
          end
        end
        LOAD_DATA: begin
          result_q <= load_value;
          state    <= IDLE;
        end
        STORE_READ: begin
          merge_q <= store_merge(mem_rdata, off_q, f3_q, rs2_q);
          state   <= STORE_WRITE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_unit.sv
// tb/tb_data_memory_unit.sv - table-driven bench for data_memory_unit with hand-written RMW, MMIO, error and reset sequences
module tb_data_memory_unit;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  subfunction_3 = 3'b0;
  logic [31:0] rs1 = 32'h0, rs2 = 32'h0, imm = 32'h0;
  logic        ld = 1'b0, st = 1'b0;
  logic [31:0] mmio_in = 32'hC300807F;
  logic        clk_stall, decoding_error, misaligned_error;
  logic [31:0] result, mmio_out;
  logic [3:0]  strobe;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_memory_unit #(.ADDRESS_SIZE(12), .MMIO_BASE(32'h2000), .MMIO_CHANNELS(4)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .subfunction_3         (subfunction_3),
    .input_register1_value (rs1),
    .input_register2_value (rs2),
    .immediate             (imm),
    .opcode_is_load        (ld),
    .opcode_is_store       (st),
    .memory_mapped_input   (mmio_in),
    .clk_stall             (clk_stall),
    .decoding_error        (decoding_error),
    .misaligned_error      (misaligned_error),
    .result_to_write_rd    (result),
    .memory_mapped_io      (mmio_out),
    .mmio_write_strobe     (strobe)
  );

  typedef struct packed {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic [31:0] rs2;
    logic [3:0]  stalls;
    logic        chk;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives one request right after a rising edge, counts stalled cycles, and
  // returns the combinational result seen in the cycle the core would advance.
  task automatic run_op(input logic l, input logic s, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] i, input logic [31:0] d,
                        output int stalls, output logic [31:0] res);
    bit done;
    ld = l; st = s; subfunction_3 = f3; rs1 = a; imm = i; rs2 = d;
    stalls = 0; res = 32'h0; done = 0;
    for (int n = 0; n < 10 && !done; n++) begin
      @(negedge clk);
      if (!clk_stall) begin
        res  = result;
        done = 1;
      end else begin
        stalls++;
      end
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL run_op timeout: got stall=1, expected stall=0 within 10 cycles");
    end
    @(posedge clk); #1;
    ld = 1'b0; st = 1'b0;
  endtask

  task automatic add(input logic l, input logic s, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] i, input logic [31:0] d, input logic [3:0] ns,
                     input logic c, input logic [31:0] r);
    vec_t v;
    v = '{ld: l, st: s, f3: f3, rs1: a, imm: i, rs2: d, stalls: ns, chk: c, res: r};
    vecs.push_back(v);
  endtask

  int          stl;
  logic [31:0] res;

  initial begin
    add(0, 1, SW,  32'h100,  32'h4,        32'hDEADBEEF, 2, 0, 32'h0);
    add(1, 0, LW,  32'h100,  32'h4,        32'h0,        1, 1, 32'hDEADBEEF);
    add(0, 1, SW,  32'h200,  32'h0,        32'h11223344, 2, 0, 32'h0);
    add(0, 1, SB,  32'h200,  32'h1,        32'h123456AA, 2, 0, 32'h0);
    add(1, 0, LW,  32'h200,  32'h0,        32'h0,        1, 1, 32'h1122AA44);
    add(1, 0, LB,  32'h200,  32'h1,        32'h0,        1, 1, 32'hFFFFFFAA);
    add(1, 0, LBU, 32'h200,  32'h1,        32'h0,        1, 1, 32'h000000AA);
    add(0, 1, SH,  32'h200,  32'h2,        32'hFFFF55AA, 2, 0, 32'h0);
    add(1, 0, LW,  32'h200,  32'h0,        32'h0,        1, 1, 32'h55AAAA44);
    add(1, 0, LH,  32'h200,  32'h2,        32'h0,        1, 1, 32'h000055AA);
    add(1, 0, LH,  32'h200,  32'h0,        32'h0,        1, 1, 32'hFFFFAA44);
    add(1, 0, LHU, 32'h200,  32'h0,        32'h0,        1, 1, 32'h0000AA44);
    add(1, 0, LW,  32'h208,  32'hFFFFFFF8, 32'h0,        1, 1, 32'h55AAAA44);
    add(1, 0, LW,  32'h4200, 32'h0,        32'h0,        1, 1, 32'h55AAAA44);
    add(1, 0, LB,  32'h2000, 32'h4,        32'h0,        0, 1, 32'hFFFFFF80);
    add(1, 0, LBU, 32'h2000, 32'h4,        32'h0,        0, 1, 32'h00000080);
    add(1, 0, LB,  32'h2000, 32'h0,        32'h0,        0, 1, 32'h0000007F);
    add(1, 0, LW,  32'h200C, 32'h0,        32'h0,        0, 1, 32'h000000C3);
    add(1, 0, LB,  32'h200C, 32'h0,        32'h0,        0, 1, 32'hFFFFFFC3);

    repeat (3) @(posedge clk);
    #1;
    check("reset result", result, 32'h0);
    check("reset mmio", mmio_out, 32'h0);
    check("reset strobe", {28'h0, strobe}, 32'h0);
    check("reset stall", {31'h0, clk_stall}, 32'h0);
    check("reset errors", {30'h0, decoding_error, misaligned_error}, 32'h0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].rs1, vecs[i].imm, vecs[i].rs2, stl, res);
      check($sformatf("vec%0d stalls", i), stl, {28'h0, vecs[i].stalls});
      if (vecs[i].chk) check($sformatf("vec%0d result", i), res, vecs[i].res);
      check($sformatf("vec%0d errors", i), {30'h0, decoding_error, misaligned_error}, 32'h0);
    end

    // MMIO store to channel 3: zero stall, byte lands, strobe pulses once
    run_op(0, 1, SB, 32'h2000, 32'hC, 32'h0000005A, stl, res);
    check("mmio store stalls", stl, 0);
    check("mmio store data", mmio_out, 32'h5A000000);
    check("mmio store strobe", {28'h0, strobe}, 32'h8);
    @(posedge clk); #1;
    check("mmio strobe clear", {28'h0, strobe}, 32'h0);
    check("mmio data held", mmio_out, 32'h5A000000);

    // Misaligned accesses: no stall, result held, no write, flag sticky
    run_op(1, 0, LW, 32'h100, 32'h0, 32'h0, stl, res);
    check("pre-misalign LW", res, 32'h00000000);
    run_op(1, 0, LW, 32'h102, 32'h0, 32'h0, stl, res);
    check("misalign LW stalls", stl, 0);
    check("misalign LW result", res, 32'h00000000);
    check("misalign flag", {31'h0, misaligned_error}, 32'h1);
    run_op(0, 1, SH, 32'h103, 32'h0, 32'h00001234, stl, res);
    check("misalign SH stalls", stl, 0);
    run_op(1, 0, LW, 32'h100, 32'h0, 32'h0, stl, res);
    check("misalign SH no write", res, 32'h00000000);
    run_op(1, 0, LW, 32'h104, 32'h0, 32'h0, stl, res);
    check("neighbour word intact", res, 32'hDEADBEEF);
    check("misalign sticky", {31'h0, misaligned_error}, 32'h1);
    check("no decode error yet", {31'h0, decoding_error}, 32'h0);

    // Illegal funct3 and load+store together
    run_op(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, stl, res);
    check("illegal f3 stalls", stl, 0);
    check("illegal f3 flag", {31'h0, decoding_error}, 32'h1);
    check("illegal f3 result held", res, 32'hDEADBEEF);
    run_op(1, 1, SW, 32'h104, 32'h0, 32'h0BADF00D, stl, res);
    check("ld+st stalls", stl, 0);
    check("ld+st flag", {31'h0, decoding_error}, 32'h1);

    // Reset while in STORE_READ: store abandoned, outputs cleared at once
    ld = 1'b0; st = 1'b1; subfunction_3 = SW; rs1 = 32'h104; imm = 32'h0; rs2 = 32'hCAFEF00D;
    @(posedge clk); #1;
    check("store_read stall", {31'h0, clk_stall}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("rst stall drop", {31'h0, clk_stall}, 32'h0);
    check("rst result", result, 32'h0);
    check("rst mmio", mmio_out, 32'h0);
    check("rst strobe", {28'h0, strobe}, 32'h0);
    check("rst errors", {30'h0, decoding_error, misaligned_error}, 32'h0);
    st = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    run_op(1, 0, LW, 32'h104, 32'h0, 32'h0, stl, res);
    check("rst word unchanged", res, 32'hDEADBEEF);
    check("post-rst stalls", stl, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
